ifid_pipe_queue: RTL
====================

# ifid_pipe_queue

Parametrised IF/ID pipeline register that replaces the single-entry IF/ID latch with a DEPTH-entry in-order queue using a valid/ready handshake, a pipeline flush, and pre-decoded instruction fields. Sits between instruction fetch (PC + instruction memory) and the decode/register-file stage. Fetch can run ahead of a stalled decode stage by up to DEPTH instructions. A taken branch or jump squashes every queued instruction in one cycle.

## Interface
- PC_W, 9, width of the fetch PC carried with each instruction
- DEPTH, 2, queue entries (≥1; any integer, not restricted to powers of two)
- J_OPC_A, 6'b000010, first opcode decoded as J-format
- J_OPC_B, 6'b000011, second opcode decoded as J-format
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept this cycle
- instruction_in  in  32  fetched instruction word
- input_pc  in  PC_W  PC of instruction_in
- flush  in  1  squash all queued entries and the current input
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode stage consumes head this cycle
- instruction_out  out  32  head instruction word
- PC  out  PC_W  head PC
- opcode  out  6  head [31:26]
- rs  out  5  head [25:21] (R/I-format), else 0
- rt  out  5  head [20:16] (R/I-format), else 0
- rd  out  5  head [15:11] (R-format), else 0
- imm16  out  16  head [15:0] (I-format), else 0
- address_26  out  26  head [25:0] (J-format), else 0
- fmt  out  2  head format: 0 R, 1 I, 2 J; 3 is never produced
- occupancy  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH entries, each holding instr[31:0], pc[PC_W-1:0] and the decoded fields. Decoding happens at enqueue time and the decoded fields are stored per entry.
- Write pointer and read pointer advance by 1 and wrap from DEPTH-1 to 0 by explicit compare. No modulo-2^n assumption is allowed.
- Decode rules:
  - opcode==0 → R: rs, rt, rd taken from the instruction; imm16=0, address_26=0.
  - opcode==J_OPC_A or J_OPC_B → J: address_26 taken from the instruction; rs=rt=rd=0, imm16=0.
  - Otherwise → I: rs, rt, imm16 taken from the instruction; rd=0, address_26=0.
  - opcode is always the raw [31:26].
- in_ready = (occupancy < DEPTH). It is a function of registered state only; there is no combinational path from out_ready.
- Enqueue when in_valid & in_ready & ~flush. Dequeue when out_valid & out_ready & ~flush.
- Simultaneous enqueue and dequeue: occupancy is unchanged and both pointers advance.
- When full, in_ready=0, even if out_ready=1 that cycle (no pass-through).
- Flush has priority over everything. On the next edge: occupancy=0, both pointers=0, and any input presented that cycle is dropped.
- out_valid = (occupancy != 0).
- When out_valid=0, all head-field outputs are driven to 0: instruction_out=0 (NOP), PC=0, fmt=0.

## Timing
- Reset (asynchronous, immediate, not waiting for clk): occupancy=0, pointers=0, out_valid=0, in_ready=1, all field outputs 0.
- Reset mid-operation discards all entries. The first accept after reset release is the next edge where in_valid=1.
- Latency: an instruction accepted at edge N is visible on outputs with out_valid=1 after edge N, i.e. one cycle later.
- Throughput: 1 instruction/cycle sustained when out_ready stays high.
- Holding: while out_ready=0, head outputs are stable; storage entries are never overwritten while valid.
- Outputs come from registers and a read-pointer mux only. There is no combinational path from any in_* input to any out_* output or to the head fields.

## Test plan
- Reset then stream: send 0x012A4020 (add, R) at PC 4, then 0x8D090008 (lw, I) at PC 8, with out_ready=1.
  - 1st result, one cycle later: fmt=0, rs=9, rt=10, rd=8, imm16=0, PC=4.
  - 2nd result: fmt=1, rs=8, rt=9, imm16=8, rd=0.
- J-format: send 0x0C000040 → fmt=2, address_26=0x40, rs=rt=rd=imm16=0. Then send 0x08000010 → fmt=2, address_26=0x10.
- Backpressure (DEPTH=2): hold out_ready=0 and offer 3 instructions.
  - 2 are accepted; in_ready=0 and occupancy=2; the 3rd is held by fetch.
  - Head outputs stay stable.
  - After releasing out_ready, the instructions drain in order with no loss or duplication.
- Flush with occupancy=2 and in_valid=1 in the same cycle: next cycle occupancy=0, out_valid=0, instruction_out=0, and the offered instruction is not stored.
- Full + out_ready=1: occupancy goes 2→1 and in_ready=0 that cycle. Repeat DEPTH=3 runs of 10 instructions to check pointer wrap-around ordering.
- Assert reset asynchronously mid-stream between clock edges: all outputs go to 0 and in_ready=1 before the next edge.

Source files
------------

// File: rtl/ifid_pipe_queue.sv
// ifid_pipe_queue
//   IF/ID pipeline register built as a DEPTH-entry in-order queue. Fetch pushes
//   instructions with a valid/ready handshake. Decode pops the head. Each
//   instruction is decoded into its R/I/J fields as it is enqueued, and those
//   fields are stored with the entry. A flush squashes every queued entry and
//   the instruction offered in the same cycle.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   in_valid/in_ready fetch-side handshake; in_ready depends on state only
//   instruction_in    fetched instruction word
//   input_pc          PC of instruction_in
//   flush             squash queue contents and the current input
//   out_valid/out_ready  decode-side handshake for the head entry
//   instruction_out, PC, opcode, rs, rt, rd, imm16, address_26, fmt
//                     head entry fields; all zero while out_valid=0
//   occupancy         number of valid entries
module ifid_pipe_queue #(
  parameter int         PC_W    = 9,
  parameter int         DEPTH   = 2,
  parameter logic [5:0] J_OPC_A = 6'b000010,
  parameter logic [5:0] J_OPC_B = 6'b000011
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instruction_in,
  input  logic [PC_W-1:0]            input_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                instruction_out,
  output logic [PC_W-1:0]            PC,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [15:0]                imm16,
  output logic [25:0]                address_26,
  output logic [1:0]                 fmt,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [1:0]      fmt;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [15:0]     imm16;
    logic [25:0]     addr26;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           enq_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             enq, deq;
  logic [5:0]       in_opc;

  // Decode at enqueue time so the head outputs are a pure storage read.
  assign in_opc = instruction_in[31:26];

  always_comb begin
    enq_entry       = '0;
    enq_entry.instr = instruction_in;
    enq_entry.pc    = input_pc;
    if (in_opc == 6'd0) begin
      enq_entry.fmt = FMT_R;
      enq_entry.rs  = instruction_in[25:21];
      enq_entry.rt  = instruction_in[20:16];
      enq_entry.rd  = instruction_in[15:11];
    end else if (in_opc == J_OPC_A || in_opc == J_OPC_B) begin
      enq_entry.fmt    = FMT_J;
      enq_entry.addr26 = instruction_in[25:0];
    end else begin
      enq_entry.fmt   = FMT_I;
      enq_entry.rs    = instruction_in[25:21];
      enq_entry.rt    = instruction_in[20:16];
      enq_entry.imm16 = instruction_in[15:0];
    end
  end

  // Full means not ready, even if the head leaves this cycle: no pass-through,
  // so in_ready never depends on out_ready.
  assign in_ready  = (occ_q < OCC_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & out_ready & ~flush;

  // Pointers wrap by explicit compare so any DEPTH works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (enq) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({enq, deq})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: its contents are only visible while out_valid=1,
  // and a slot is written only when it is free.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_entry;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign instruction_out = head.instr;
  assign PC              = head.pc;
  assign opcode          = head.instr[31:26];
  assign rs              = head.rs;
  assign rt              = head.rt;
  assign rd              = head.rd;
  assign imm16           = head.imm16;
  assign address_26      = head.addr26;
  assign fmt             = head.fmt;
  assign occupancy       = occ_q;

endmodule
